// File: rtl/fixed_leaky_relu_stream_ctrl_if.sv
// Stream bundle for the leaky-ReLU controller: config, input block and output block channels.
// Latency: none (wires only).
// Backpressure: valid/ready on every channel; the master drives cfg/data_in and data_out_0_ready.
//
// Ports (as seen from the design, slave modport):
//   cfg_slope_exp/cfg_valid in, cfg_ready out      -- slope exponent, starts a tensor
//   data_in_0[P]/data_in_0_valid in, data_in_0_ready out
//   data_out_0[P]/data_out_0_valid/data_out_0_last out, data_out_0_ready in
//   busy, tensor_done out                          -- status
interface fixed_leaky_relu_stream_ctrl_if #(
  parameter int PREC            = 8,
  parameter int P               = 2,
  parameter int SLOPE_EXP_WIDTH = 4
);
  logic [SLOPE_EXP_WIDTH-1:0] cfg_slope_exp;
  logic                       cfg_valid;
  logic                       cfg_ready;

  logic [PREC-1:0]            data_in_0 [P];
  logic                       data_in_0_valid;
  logic                       data_in_0_ready;

  logic [PREC-1:0]            data_out_0 [P];
  logic                       data_out_0_valid;
  logic                       data_out_0_ready;
  logic                       data_out_0_last;

  logic                       busy;
  logic                       tensor_done;

  modport master (
    output cfg_slope_exp, cfg_valid, data_in_0, data_in_0_valid, data_out_0_ready,
    input  cfg_ready, data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last,
    input  busy, tensor_done
  );

  modport slave (
    input  cfg_slope_exp, cfg_valid, data_in_0, data_in_0_valid, data_out_0_ready,
    output cfg_ready, data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last,
    output busy, tensor_done
  );
endinterface

// File: rtl/fixed_leaky_relu_stream_ctrl.sv
// Fixed-point leaky ReLU over a tensor streamed as P-element blocks; negative values >>> slope.
// Latency: 1 cycle from input accept to data_out_0_valid when the output buffer is empty.
// Backpressure: 2-entry output buffer; data_in_0_ready drops when it is full, never from data_out_0_ready.
//
// Ports: clk (rising edge), rst (synchronous, active high), io_s (slave side of the stream bundle:
//   config handshake, input block stream, output block stream with last flag, busy, tensor_done).
// Tensor dims must be exact multiples of the matching parallelism.
module fixed_leaky_relu_stream_ctrl #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SLOPE_EXP_WIDTH             = 4,
  parameter int NEGATIVE_SLOPE_EXP          = 2
) (
  input logic                           clk,
  input logic                           rst,
  fixed_leaky_relu_stream_ctrl_if.slave io_s
);
  localparam int PREC  = DATA_IN_0_PRECISION_0;
  localparam int P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int NBLK  = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                         (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CNT_W = $clog2(NBLK + 1);
  localparam logic [CNT_W-1:0] NBLK_C = CNT_W'(NBLK);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NBLK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [SLOPE_EXP_WIDTH-1:0] r_slope;
  logic [CNT_W-1:0]           r_in_cnt;
  logic [CNT_W-1:0]           r_out_cnt;

  logic [PREC-1:0]            r_mem [2][P];
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_occ;

  logic                       w_cfg_rdy;
  logic                       w_cfg_fire;
  logic                       w_in_rdy;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_out_vld;
  logic                       w_out_last;
  logic                       w_done;
  logic                       w_sat;
  logic [PREC-1:0]            w_res [P];

  // Outputs are forced to idle values while rst is high, so the bus is quiet
  // during reset even though the registers only clear on the edge.
  assign w_out_vld  = (r_occ != 2'd0) && !rst;
  assign w_pop      = w_out_vld && io_s.data_out_0_ready;
  // The head of the buffer is always block number out_cnt of the tensor.
  assign w_out_last = w_out_vld && (r_out_cnt == LAST_C);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_rdy   = 1'b0;
    w_cfg_fire  = 1'b0;
    w_in_rdy    = 1'b0;
    w_push      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cfg_rdy  = !rst;
        w_cfg_fire = w_cfg_rdy && io_s.cfg_valid;
        if (w_cfg_fire) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_in_rdy = !rst && (r_in_cnt < NBLK_C) && (r_occ != 2'd2);
        w_push   = w_in_rdy && io_s.data_in_0_valid;
        if (w_push && (r_in_cnt == LAST_C)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_done = w_pop && w_out_last;
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- config and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slope   <= SLOPE_EXP_WIDTH'(NEGATIVE_SLOPE_EXP);
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_cfg_fire) begin
      r_slope   <= io_s.cfg_slope_exp;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_push) r_in_cnt  <= r_in_cnt + 1'b1;
      if (w_pop)  r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------- datapath
  // A shift of PREC or more would already give -1 for negatives, but the
  // explicit saturation keeps the result independent of shifter width.
  assign w_sat = int'(r_slope) >= PREC;

  always_comb begin
    for (int i = 0; i < P; i++) begin
      w_res[i] = io_s.data_in_0[i];
      if (io_s.data_in_0[i][PREC-1]) begin
        if (w_sat) w_res[i] = '1;
        else       w_res[i] = $signed(io_s.data_in_0[i]) >>> r_slope;
      end
    end
  end

  // ------------------------------------------------------ 2-entry buffer
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < P; i++) r_mem[r_wr_ptr][i] <= w_res[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    for (int i = 0; i < P; i++) begin
      io_s.data_out_0[i] = w_out_vld ? r_mem[r_rd_ptr][i] : '0;
    end
  end

  assign io_s.cfg_ready        = w_cfg_rdy;
  assign io_s.data_in_0_ready  = w_in_rdy;
  assign io_s.data_out_0_valid = w_out_vld;
  assign io_s.data_out_0_last  = w_out_last;
  assign io_s.busy             = (r_state != S_IDLE) && !rst;
  assign io_s.tensor_done      = w_done;
endmodule

// File: tb/tb_fixed_leaky_relu_stream_ctrl.sv
module tb_fixed_leaky_relu_stream_ctrl;
  localparam int NBLK = 4;

  typedef struct packed {
    logic        last;
    logic [15:0] d;     // {element1, element0}
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fixed_leaky_relu_stream_ctrl_if #(.PREC(8), .P(2), .SLOPE_EXP_WIDTH(4)) bus ();

  fixed_leaky_relu_stream_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .io_s (bus)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_cnt     = 0;
  int   n_acc        = 0;
  int   cyc          = 0;
  logic rdy_rand     = 1'b0;
  logic rdy_force    = 1'b1;

  // model state
  blk_t q[$];
  logic m_busy   = 1'b0;
  int   m_in_idx = 0;
  int   m_slope  = 2;
  blk_t log_q[$];
  int   log_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Leaky ReLU as floor division by 2^e for negatives.
  function automatic logic [7:0] leaky(input logic [7:0] x, input int e);
    int v, d;
    v = int'($signed(x));
    if (v >= 0) return x;
    d = 1 << e;
    return 8'((v - (d - 1)) / d);
  endfunction

  // ----------------------------------------------------- compare process
  logic        stall_prev = 1'b0;
  logic        after_rst  = 1'b0;
  logic [15:0] prev_d     = '0;
  logic        prev_last  = 1'b0;

  always @(negedge clk) begin : cmp
    logic        e_out_vld, e_in_rdy, out_fire, in_fire, e_done, cfg_fire;
    logic [15:0] cur_d;
    blk_t        b;
    cur_d = {bus.data_out_0[1], bus.data_out_0[0]};
    if (rst) begin
      chk("rst_out_vld", bus.data_out_0_valid, 0);
      chk("rst_in_rdy", bus.data_in_0_ready, 0);
      chk("rst_done", bus.tensor_done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_last", bus.data_out_0_last, 0);
      chk("rst_cfg_rdy", bus.cfg_ready, 0);
      chk("rst_dat", cur_d, 0);
      q.delete();
      m_busy     = 1'b0;
      m_in_idx   = 0;
      stall_prev = 1'b0;
      after_rst  = 1'b1;
    end else begin
      e_out_vld = (q.size() != 0);
      e_in_rdy  = m_busy && (m_in_idx < NBLK) && (q.size() < 2);
      cfg_fire  = !m_busy && bus.cfg_valid;
      chk("out_vld", bus.data_out_0_valid, e_out_vld);
      chk("in_rdy", bus.data_in_0_ready, e_in_rdy);
      chk("cfg_rdy", bus.cfg_ready, !m_busy);
      chk("busy", bus.busy, m_busy);
      if (after_rst) begin
        chk("post_rst_dat", cur_d, 0);
        chk("post_rst_last", bus.data_out_0_last, 0);
      end
      if (stall_prev) begin
        chk("hold_vld", bus.data_out_0_valid, 1);
        chk("hold_dat", cur_d, prev_d);
        chk("hold_last", bus.data_out_0_last, prev_last);
      end
      out_fire = e_out_vld && bus.data_out_0_ready;
      e_done   = out_fire && q[0].last;
      if (e_out_vld) begin
        chk("out_dat", cur_d, q[0].d);
        chk("out_last", bus.data_out_0_last, q[0].last);
      end
      chk("tensor_done", bus.tensor_done, e_done);
      if (bus.tensor_done) done_cnt++;
      if (bus.data_out_0_valid && bus.data_out_0_ready) begin
        b.d    = cur_d;
        b.last = bus.data_out_0_last;
        log_q.push_back(b);
        log_cyc.push_back(cyc);
      end
      if (out_fire) void'(q.pop_front());
      if (e_done) m_busy = 1'b0;
      in_fire = e_in_rdy && bus.data_in_0_valid;
      if (in_fire) begin
        b.d    = {leaky(bus.data_in_0[1], m_slope), leaky(bus.data_in_0[0], m_slope)};
        b.last = (m_in_idx == NBLK - 1);
        q.push_back(b);
        m_in_idx++;
      end
      if (cfg_fire) begin
        m_busy   = 1'b1;
        m_slope  = int'(bus.cfg_slope_exp);
        m_in_idx = 0;
      end
      stall_prev = bus.data_out_0_valid && !bus.data_out_0_ready;
      prev_d     = cur_d;
      prev_last  = bus.data_out_0_last;
      after_rst  = 1'b0;
    end
    cyc++;
  end

  // ------------------------------------------------- output ready driver
  initial begin
    bus.data_out_0_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.data_out_0_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // ------------------------------------------------------------- tasks
  task automatic send_cfg(input logic [3:0] e);
    int n = 0;
    bus.cfg_slope_exp = e;
    bus.cfg_valid     = 1'b1;
    @(negedge clk);
    while (!bus.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_hs_timeout", bus.cfg_ready, 1);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.data_in_0[0]    = a;
    bus.data_in_0[1]    = b;
    bus.data_in_0_valid = 1'b1;
    @(negedge clk);
    while (!bus.data_in_0_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("in_hs_timeout", bus.data_in_0_ready, 1);
    @(posedge clk);
    #1;
    bus.data_in_0_valid = 1'b0;
    n_acc++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("idle_timeout", bus.busy, 0);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int d0;
    bus.cfg_valid       = 1'b0;
    bus.cfg_slope_exp   = '0;
    bus.data_in_0_valid = 1'b0;
    bus.data_in_0[0]    = '0;
    bus.data_in_0[1]    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // model pinned to hand-computed values
    chk("model_10_e2", leaky(8'h10, 2), 8'h10);
    chk("model_F0_e2", leaky(8'hF0, 2), 8'hFC);
    chk("model_80_e2", leaky(8'h80, 2), 8'hE0);
    chk("model_FC_e2", leaky(8'hFC, 2), 8'hFF);
    chk("model_80_e9", leaky(8'h80, 9), 8'hFF);
    chk("model_05_e9", leaky(8'h05, 9), 8'h05);

    // basic tensor with literal results
    log_q.delete(); log_cyc.delete(); d0 = done_cnt;
    send_cfg(4'd2);
    send_block(8'h10, 8'hF0);
    send_block(8'h00, 8'h80);
    send_block(8'h7F, 8'hFF);
    send_block(8'h01, 8'hFC);
    wait_idle();
    chk("basic_cnt", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("basic_b0", log_q[0], {1'b0, 16'hFC10});
      chk("basic_b1", log_q[1], {1'b0, 16'hE000});
      chk("basic_b2", log_q[2], {1'b0, 16'hFF7F});
      chk("basic_b3", log_q[3], {1'b1, 16'hFF01});
    end
    chk("basic_done", done_cnt - d0, 1);

    // exponent beyond element width saturates negatives
    log_q.delete(); log_cyc.delete();
    send_cfg(4'd9);
    send_block(8'h80, 8'h05);
    send_block(8'hFE, 8'h7F);
    send_block(8'h00, 8'hC0);
    send_block(8'h01, 8'h81);
    wait_idle();
    chk("sat_cnt", log_q.size(), 4);
    if (log_q.size() == 4) chk("sat_b0", log_q[0].d, 16'h05FF);

    // output stall: two blocks buffered, then full-rate release
    log_q.delete(); log_cyc.delete(); n_acc = 0;
    rdy_force = 1'b0;
    send_cfg(4'd1);
    fork
      begin
        send_block(8'h90, 8'h11);
        send_block(8'h22, 8'hA0);
        send_block(8'hF1, 8'h33);
        send_block(8'h44, 8'hE2);
      end
      begin
        repeat (7) @(negedge clk);
        chk("stall_in_rdy", bus.data_in_0_ready, 0);
        chk("stall_out_vld", bus.data_out_0_valid, 1);
        chk("stall_acc", n_acc, 2);
        chk("stall_no_out", log_q.size(), 0);
        rdy_force = 1'b1;
      end
    join
    wait_idle();
    chk("stall_cnt", log_q.size(), 4);
    if (log_q.size() == 4) chk("stall_rate", log_cyc[3] - log_cyc[0], 3);

    // cfg during RUN is ignored
    log_q.delete(); log_cyc.delete();
    send_cfg(4'd3);
    send_block(8'h80, 8'h40);
    bus.cfg_slope_exp = 4'd0;
    bus.cfg_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    send_block(8'h80, 8'hF8);
    send_block(8'h08, 8'h00);
    send_block(8'hFF, 8'h01);
    wait_idle();
    chk("cfgign_cnt", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("cfgign_b0", log_q[0].d, 16'h40F0);
      chk("cfgign_b1", log_q[1].d, 16'hFFF0);
    end

    // reset mid-tensor, then a clean tensor
    d0 = done_cnt;
    send_cfg(4'd2);
    send_block(8'h81, 8'h02);
    send_block(8'h03, 8'h84);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    log_q.delete(); log_cyc.delete();
    send_cfg(4'd2);
    send_block(8'h10, 8'hF0);
    send_block(8'h00, 8'h80);
    send_block(8'h7F, 8'hFF);
    send_block(8'h01, 8'hFC);
    wait_idle();
    chk("rst_clean_cnt", log_q.size(), 4);
    chk("rst_clean_done", done_cnt - d0, 1);

    // random valid/ready stalls over 100 tensors
    d0 = done_cnt;
    rdy_rand = 1'b1;
    for (int t = 0; t < 100; t++) begin
      send_cfg(4'($urandom_range(0, 15)));
      for (int k = 0; k < NBLK; k++) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
        send_block(8'($urandom), 8'($urandom));
      end
      wait_idle();
    end
    rdy_rand = 1'b0;
    chk("rand_done", done_cnt - d0, 100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", tests_failed);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fixed_leaky_relu_stream_ctrl.md
FIXED_LEAKY_RELU_STREAM_CTRL -- requirements
Module: fixed_leaky_relu_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8, element width in bits (signed two's complement).
REQ-002 SHALL have parameter DATA_IN_0_TENSOR_SIZE_DIM_0, default 8, and DATA_IN_0_TENSOR_SIZE_DIM_1, default 1: tensor shape.
REQ-003 SHALL have parameter DATA_IN_0_PARALLELISM_DIM_0, default 2, and DATA_IN_0_PARALLELISM_DIM_1, default 1: block shape; each tensor dim SHALL be an exact multiple of its parallelism.
REQ-004 SHALL have parameter SLOPE_EXP_WIDTH, default 4, width of the runtime slope exponent.
REQ-005 SHALL have parameter NEGATIVE_SLOPE_EXP, default 2, reset value of the slope exponent (slope = 2^-exp).
REQ-006 SHALL define derived constants P = PAR_DIM_0*PAR_DIM_1 and NBLK = (SIZE_DIM_0/PAR_DIM_0)*(SIZE_DIM_1/PAR_DIM_1).
REQ-007 SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-008 cfg_slope_exp input SLOPE_EXP_WIDTH; slope exponent for the next tensor.
REQ-009 cfg_valid input 1 / cfg_ready output 1; config handshake, also starts a tensor.
REQ-010 data_in_0 input P x DATA_IN_0_PRECISION_0 unpacked array; data_in_0_valid input 1; data_in_0_ready output 1.
REQ-011 data_out_0 output P x DATA_IN_0_PRECISION_0 unpacked array; data_out_0_valid output 1; data_out_0_ready input 1; data_out_0_last output 1 (final block of the tensor).
REQ-012 busy output 1 (state != IDLE); tensor_done output 1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-014 IDLE: cfg_ready=1, data_in_0_ready=0; on cfg_valid: latch cfg_slope_exp into slope_q, clear in_cnt/out_cnt, go to RUN.
REQ-015 RUN: cfg_ready=0; data_in_0_ready = (in_cnt < NBLK) && (occ < 2), where occ is output-buffer occupancy; ready SHALL NOT depend combinationally on data_out_0_ready.
REQ-016 Each accepted block (valid&&ready) SHALL increment in_cnt; when the NBLK-th block is accepted, go to DRAIN the next cycle.
REQ-017 Per element: if signed value < 0, out = value >>> slope_q (arithmetic); else out = value; zero passes as zero.
REQ-018 slope_q >= DATA_IN_0_PRECISION_0 SHALL yield -1 (all ones) for every negative input.
REQ-019 Results SHALL enter a 2-entry FIFO; latency input accept -> data_out_0_valid SHALL be exactly 1 cycle when the FIFO is empty.
REQ-020 Sustained throughput SHALL be 1 block/cycle while data_out_0_ready=1; simultaneous push and pop at occ=1 SHALL keep occ=1.
REQ-021 data_out_0 and data_out_0_last SHALL hold stable while valid && !ready.
REQ-022 data_out_0_last SHALL be 1 only on the block with out_cnt == NBLK-1.
REQ-023 DRAIN: data_in_0_ready=0; on the handshake of the last block, pulse tensor_done for one cycle and return to IDLE the same cycle.
REQ-024 cfg_valid outside IDLE SHALL be ignored; slope_q SHALL NOT change mid-tensor.
REQ-025 NBLK=1 SHALL go IDLE -> RUN -> DRAIN with that single block flagged last.

Reset
REQ-026 On rst: state=IDLE, in_cnt=out_cnt=occ=0, slope_q=NEGATIVE_SLOPE_EXP; reset SHALL have priority over all handshakes.
REQ-027 During reset and the cycle after, data_out_0_valid=0, data_in_0_ready=0, tensor_done=0, busy=0, data_out_0_last=0, data_out_0 = all zeros; cfg_ready=0 during reset, 1 after.
REQ-028 Reset mid-tensor SHALL discard buffered data and in-flight counts; no tensor_done pulse.

Verification (PREC=8, DIM_0=8, DIM_1=1, PAR_0=2, so NBLK=4)
REQ-029 cfg 2, blocks {8'h10,8'hF0},{8'h00,8'h80},{8'h7F,8'hFF},{8'h01,8'hFC}, out_ready=1 -> {10,FC},{00,E0},{7F,FF},{01,FF}; last on 4th only; tensor_done once.
REQ-030 cfg 9, input 8'h80 -> 8'hFF; input 8'h05 -> 8'h05.
REQ-031 out_ready=0 for 5 cycles mid-stream -> exactly 2 blocks buffered, in_ready=0, outputs stable; release -> no loss or duplication, 1 block/cycle.
REQ-032 cfg_valid pulsed during RUN with exp 0 -> ignored; results still use the latched exponent.
REQ-033 rst asserted after 2 of 4 blocks -> outputs at reset values next cycle, no tensor_done; new cfg -> clean 4-block tensor.
REQ-034 Random valid/ready stalls over 100 tensors -> output matches reference model, tensor_done count = 100.
